// File: rtl/utpu_pkg.sv
// Shared types for the uTPU instruction sequencer: opcodes, sequencer states
// and instruction field offsets.
package utpu_pkg;

    typedef enum logic [2:0] {
        OP_STORE = 3'd0,
        OP_FETCH = 3'd1,
        OP_RUN   = 3'd2,
        OP_LOAD  = 3'd3,
        OP_HALT  = 3'd4,
        OP_NOP   = 3'd5
    } opcode_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH_RD,
        S_FETCH_CAP,
        S_DECODE,
        S_ADDR_RD,
        S_ADDR_CAP,
        S_ISSUE,
        S_WAIT_DONE,
        S_HALT
    } seq_state_e;

    // On STORE, flag bit 0 announces an extended address word after the instruction.
    localparam int FLAG_EXT_ADDR_BIT = 0;

    // Opcode sits at the bottom of the word; flags follow directly above it.
    localparam int OPCODE_LSB = 0;

endpackage

// File: rtl/instr_sequencer_byte_assembler.sv
// byte_assembler: collects N_BYTES little-endian bytes over the rx_re/rx_data
// protocol (read strobe in one cycle, data captured in the next).
module byte_assembler #(
    parameter int DATA_W  = 8,
    parameter int N_BYTES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rd_en,
    input  logic                      cap_en,
    input  logic                      rx_empty,
    input  logic [DATA_W-1:0]         rx_data,
    output logic                      rx_re,
    output logic [N_BYTES*DATA_W-1:0] word,
    output logic                      word_valid
);

    localparam int IDX_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [N_BYTES*DATA_W-1:0] word_q, word_d;
    logic                      last_byte;

    assign last_byte  = (idx_q == LAST_IDX);
    assign rx_re      = rd_en & ~rx_empty;
    assign word_valid = cap_en & last_byte;
    // Exposes the next value so the byte captured in this cycle is already visible with word_valid.
    assign word       = word_d;

    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (cap_en) begin
            for (int i = 0; i < N_BYTES; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    word_d[i*DATA_W +: DATA_W] = rx_data;
                end
            end
            idx_d = last_byte ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// uTPU instruction fetch/decode/issue controller. Optional done watchdog and
// timeout_err output are enabled with `define INSTR_SEQ_TIMEOUT_EN.
module instr_sequencer
    import utpu_pkg::*;
#(
    parameter int FIFO_DATA_WIDTH = 8,
    parameter int INSTR_BYTES     = 2,
    parameter int ADDR_WIDTH      = 9,
    parameter int ADDR_BYTES      = 2,
    parameter int OPCODE_WIDTH    = 3,
    parameter int FLAG_WIDTH      = 3,
    parameter int COUNT_WIDTH     = 16
`ifdef INSTR_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES  = 1024
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       rx_empty,
    output logic                       rx_re,
    input  logic [FIFO_DATA_WIDTH-1:0] rx_data,
    output logic                       cmd_valid,
    input  logic                       cmd_ready,
    output logic [OPCODE_WIDTH-1:0]    cmd_op,
    output logic [ADDR_WIDTH-1:0]      cmd_addr,
    output logic [FLAG_WIDTH-1:0]      cmd_flags,
    input  logic                       done,
    output logic                       busy,
    output logic                       halted,
    output logic                       err_illegal,
    output logic [COUNT_WIDTH-1:0]     instr_count
`ifdef INSTR_SEQ_TIMEOUT_EN
    ,
    output logic                       timeout_err
`endif
);

    localparam int INSTR_W     = INSTR_BYTES * FIFO_DATA_WIDTH;
    localparam int ADDR_WORD_W = ADDR_BYTES * FIFO_DATA_WIDTH;

    seq_state_e                 state_q, state_d;
    logic [COUNT_WIDTH-1:0]     instr_count_q, instr_count_d;
    logic                       err_illegal_q, err_illegal_d;
    logic [OPCODE_WIDTH-1:0]    cmd_op_q, cmd_op_d;
    logic [ADDR_WIDTH-1:0]      cmd_addr_q, cmd_addr_d;
    logic [FLAG_WIDTH-1:0]      cmd_flags_q, cmd_flags_d;

    logic [INSTR_W-1:0]         instr_word;
    logic [ADDR_WORD_W-1:0]     addr_word;
    logic                       instr_valid, addr_valid;
    logic                       instr_rx_re, addr_rx_re;
    logic [OPCODE_WIDTH-1:0]    op_field;
    logic [FLAG_WIDTH-1:0]      flag_field;
    logic [ADDR_WIDTH-1:0]      addr_field;
    logic                       unused_bits;

    byte_assembler #(.DATA_W(FIFO_DATA_WIDTH), .N_BYTES(INSTR_BYTES)) u_instr_asm (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (state_q == S_FETCH_RD),
        .cap_en     (state_q == S_FETCH_CAP),
        .rx_empty   (rx_empty),
        .rx_data    (rx_data),
        .rx_re      (instr_rx_re),
        .word       (instr_word),
        .word_valid (instr_valid)
    );

    byte_assembler #(.DATA_W(FIFO_DATA_WIDTH), .N_BYTES(ADDR_BYTES)) u_addr_asm (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (state_q == S_ADDR_RD),
        .cap_en     (state_q == S_ADDR_CAP),
        .rx_empty   (rx_empty),
        .rx_data    (rx_data),
        .rx_re      (addr_rx_re),
        .word       (addr_word),
        .word_valid (addr_valid)
    );

    assign op_field    = instr_word[OPCODE_LSB +: OPCODE_WIDTH];
    assign flag_field  = instr_word[OPCODE_LSB + OPCODE_WIDTH +: FLAG_WIDTH];
    assign addr_field  = instr_word[INSTR_W-1 -: ADDR_WIDTH];
    assign unused_bits = ^{instr_word, addr_word};

`ifdef INSTR_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_err_q, timeout_err_d;
`endif

    always_comb begin
        state_d       = state_q;
        instr_count_d = instr_count_q;
        err_illegal_d = err_illegal_q;
        cmd_op_d      = cmd_op_q;
        cmd_addr_d    = cmd_addr_q;
        cmd_flags_d   = cmd_flags_q;
`ifdef INSTR_SEQ_TIMEOUT_EN
        to_cnt_d      = to_cnt_q;
        timeout_err_d = timeout_err_q;
`endif
        case (state_q)
            S_IDLE:      if (start) state_d = S_FETCH_RD;
            S_FETCH_RD:  if (!rx_empty) state_d = S_FETCH_CAP;
            S_FETCH_CAP: state_d = instr_valid ? S_DECODE : S_FETCH_RD;
            S_DECODE: begin
                instr_count_d = instr_count_q + COUNT_WIDTH'(1);
                cmd_op_d      = op_field;
                cmd_flags_d   = flag_field;
                cmd_addr_d    = addr_field;
                case (op_field)
                    OPCODE_WIDTH'(OP_STORE):
                        state_d = flag_field[FLAG_EXT_ADDR_BIT] ? S_ADDR_RD : S_ISSUE;
                    OPCODE_WIDTH'(OP_FETCH),
                    OPCODE_WIDTH'(OP_RUN),
                    OPCODE_WIDTH'(OP_LOAD):  state_d = S_ISSUE;
                    OPCODE_WIDTH'(OP_HALT):  state_d = S_HALT;
                    OPCODE_WIDTH'(OP_NOP):   state_d = S_FETCH_RD;
                    default: begin
                        err_illegal_d = 1'b1;
                        state_d       = S_FETCH_RD;
                    end
                endcase
            end
            S_ADDR_RD:   if (!rx_empty) state_d = S_ADDR_CAP;
            S_ADDR_CAP: begin
                if (addr_valid) begin
                    cmd_addr_d = addr_word[ADDR_WIDTH-1:0];
                    state_d    = S_ISSUE;
                end else begin
                    state_d    = S_ADDR_RD;
                end
            end
            S_ISSUE: begin
                if (cmd_ready) begin
                    state_d = S_WAIT_DONE;
`ifdef INSTR_SEQ_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end
            end
            S_WAIT_DONE: begin
                if (done) begin
                    state_d = S_FETCH_RD;
`ifdef INSTR_SEQ_TIMEOUT_EN
                end else if (to_cnt_q == TO_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_FETCH_RD;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
`endif
                end
            end
            S_HALT:      if (start) state_d = S_FETCH_RD;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            instr_count_q <= '0;
            err_illegal_q <= 1'b0;
            cmd_op_q      <= '0;
            cmd_addr_q    <= '0;
            cmd_flags_q   <= '0;
`ifdef INSTR_SEQ_TIMEOUT_EN
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
            err_illegal_q <= err_illegal_d;
            cmd_op_q      <= cmd_op_d;
            cmd_addr_q    <= cmd_addr_d;
            cmd_flags_q   <= cmd_flags_d;
`ifdef INSTR_SEQ_TIMEOUT_EN
            to_cnt_q      <= to_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign rx_re       = instr_rx_re | addr_rx_re;
    assign cmd_valid   = (state_q == S_ISSUE);
    assign cmd_op      = cmd_op_q;
    assign cmd_addr    = cmd_addr_q;
    assign cmd_flags   = cmd_flags_q;
    assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted      = (state_q == S_HALT);
    assign err_illegal = err_illegal_q;
    assign instr_count = instr_count_q;
`ifdef INSTR_SEQ_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`endif

endmodule
